debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//  N-channel push-button/switch conditioner: per-channel 2-flop synchroniser, debounce filter,
//  clean level, one-cycle rise/fall pulses and optional auto-repeat "press" pulses.
//  Sits between raw KEY/SW pins and control FSMs; replaces per-key debounce + edge-detect pairs.
// PARAMETERS
//  N               4           number of independent channels (>=1)
//  CLK_HZ          50_000_000  clock frequency in Hz
//  DEBOUNCE_MS     30          required stable time in ms; PERIOD = CLK_HZ/1000*DEBOUNCE_MS cycles
//  REPEAT_EN       0           1 = auto-repeat press pulses while level held high
//  REPEAT_DELAY_MS 500         hold time before first repeat; RDLY = CLK_HZ/1000*REPEAT_DELAY_MS
//  REPEAT_RATE_MS  100         interval between later repeats; RRATE = CLK_HZ/1000*REPEAT_RATE_MS
// PORTS
//  clk    in   1  system clock; all state updates on posedge
//  reset  in   1  synchronous, active-high reset
//  x      in   N  raw asynchronous inputs, active-high
//  level  out  N  debounced level per channel
//  rise   out  N  1-cycle pulse when level goes 0->1
//  fall   out  N  1-cycle pulse when level goes 1->0
//  press  out  N  rise OR repeat pulse (repeat only when REPEAT_EN=1)
//  any    out  1  OR of level[N-1:0], combinational from level
// BEHAVIOUR
//  - Elaboration: PERIOD, RDLY, RRATE must each be >=1; otherwise $error. Counter widths are
//    $clog2(max+1).
//  - Reset (sampled at posedge): sync flops, level, rise, fall, press, all counters <= 0.
//    Reset wins over every other event in the same cycle.
//  - Synchroniser: x_syn[i] = x[i] delayed by 2 clocks.
//  - Debounce, channel i:
//    * x_syn==level: cnt <= 0.
//    * x_syn!=level and cnt<PERIOD-1: cnt <= cnt+1.
//    * x_syn!=level and cnt==PERIOD-1: level <= ~level, cnt <= 0.
//    * level flips after PERIOD consecutive mismatch cycles. Pin-to-level latency is
//      PERIOD+2 clocks.
//    * One matching cycle (bounce) restarts the count from 0.
//  - rise/fall: registered in the same edge as the level flip, high exactly 1 cycle; never both.
//  - Repeat FSM per channel; states IDLE, DELAY, REPEAT; rcnt counter:
//    * IDLE: on rise -> DELAY, rcnt <= 0.
//    * DELAY: rcnt++; on rcnt==RDLY-1, repeat pulse, rcnt <= 0, -> REPEAT.
//    * REPEAT: rcnt++; on rcnt==RRATE-1, repeat pulse, rcnt <= 0.
//    * Any state: fall or level==0 -> IDLE, with no pulse that cycle.
//    * REPEAT_EN=0: FSM held in IDLE; press == rise.
//    * Net effect: press at t0 (rise), t0+RDLY, then every RRATE cycles while held.
//  - Channels are fully independent; simultaneous events on different channels never interact.
//  - Counters saturate logically by the wrap rules above; no overflow is reachable.
//  - Reset mid-debounce or mid-repeat: count discarded, level 0. A held input re-qualifies
//    PERIOD+2 cycles after reset deasserts and produces a fresh rise.
// TESTING (bench params: N=4, CLK_HZ=1000, DEBOUNCE_MS=4, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=3
//          => PERIOD=4, RDLY=10, RRATE=3)
//  1. reset 2 cycles; x=0000 -> level/rise/fall/press all 0, any=0.
//  2. x[0] 0->1 at edge 0, held -> level[0]=1 from edge 6; rise[0],press[0] high edge 6..7 only;
//     any=1.
//  3. x[1] bounce: 1 for 3 cycles, 0 for 1, then 1 held -> level[1] rises exactly 6 cycles
//     after final 0->1; no earlier rise.
//  4. REPEAT_EN=1, x[2] held 30 cycles after rise at t0 -> press[2] at t0, t0+10, t0+13,
//     t0+16...; release -> fall[2] 6 cycles later, no further press. REPEAT_EN=0 -> single press.
//  5. x[3] high, reset pulsed 1 cycle after 3 mismatch cycles -> level[3] stays 0; level[3]
//     rises 6 cycles after reset deasserts.
//  6. x[0] falls and x[1] rises on same edge -> fall[0] and rise[1] on same cycle, 6 cycles
//     later; other channels unchanged.

Source files
------------

// File: rtl/debounce_bank.sv
// N-channel input conditioner: 2-flop synchroniser, debounce filter, clean level,
// one-cycle rise/fall pulses and optional auto-repeat press pulses.
module debounce_bank #(
  parameter int N               = 4,
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_MS     = 30,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] x,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] press,
  output logic         any
);

  localparam int PERIOD = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int RDLY   = CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int RRATE  = CLK_HZ / 1000 * REPEAT_RATE_MS;
  localparam int RMAX   = (RDLY > RRATE) ? RDLY : RRATE;
  localparam int CW     = $clog2(PERIOD + 1);
  localparam int RW     = $clog2(RMAX + 1);

  if (PERIOD < 1 || RDLY < 1 || RRATE < 1) begin : g_bad_param
    $error("debounce_bank: PERIOD, RDLY and RRATE must all be >= 1");
  end

  typedef enum logic [1:0] {
    R_IDLE,
    R_DELAY,
    R_REPEAT
  } rep_state_e;

  logic [N-1:0] sync1_q, sync2_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= x;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          press_q, press_d;
    logic          rep_pulse;
    rep_state_e    state_q, state_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q[i] != level_q) begin
        if (cnt_q == CW'(PERIOD - 1)) level_d = ~level_q;
        else                          cnt_d   = cnt_q + 1'b1;
      end
      rise_d = level_d & ~level_q;
      fall_d = ~level_d & level_q;
    end

    // Repeat FSM decides from level_d so the rise edge and the DELAY entry share one clock.
    always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      rep_pulse = 1'b0;
      if (REPEAT_EN == 0 || !level_d) begin
        state_d = R_IDLE;
        rcnt_d  = '0;
      end else begin
        case (state_q)
          R_IDLE: begin
            if (rise_d) begin
              state_d = R_DELAY;
              rcnt_d  = '0;
            end
          end
          R_DELAY: begin
            if (rcnt_q == RW'(RDLY - 1)) begin
              rep_pulse = 1'b1;
              rcnt_d    = '0;
              state_d   = R_REPEAT;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
          R_REPEAT: begin
            if (rcnt_q == RW'(RRATE - 1)) begin
              rep_pulse = 1'b1;
              rcnt_d    = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
          default: begin
            state_d = R_IDLE;
            rcnt_d  = '0;
          end
        endcase
      end
      press_d = rise_d | rep_pulse;
    end

    // NOTE: reset clears all state, including counters, so a held input re-qualifies from scratch.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q   <= '0;
        rcnt_q  <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        press_q <= 1'b0;
        state_q <= R_IDLE;
      end else begin
        cnt_q   <= cnt_d;
        rcnt_q  <= rcnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        press_q <= press_d;
        state_q <= state_d;
      end
    end

    assign level[i] = level_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
    assign press[i] = press_q;
  end

  assign any = |level;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: PERIOD=4, RDLY=10, RRATE=3, with and without auto-repeat.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] x;
  logic [3:0] level, rise, fall, press;
  logic       any;
  logic [3:0] nr_level, nr_rise, nr_fall, nr_press;
  logic       nr_any;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .N(4), .CLK_HZ(1000), .DEBOUNCE_MS(4), .REPEAT_EN(1),
    .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(3)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .level(level), .rise(rise),
    .fall(fall), .press(press), .any(any)
  );

  debounce_bank #(
    .N(4), .CLK_HZ(1000), .DEBOUNCE_MS(4), .REPEAT_EN(0),
    .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(3)
  ) dut_nr (
    .clk(clk), .reset(reset), .x(x), .level(nr_level), .rise(nr_rise),
    .fall(nr_fall), .press(nr_press), .any(nr_any)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one posedge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        early;
    logic [63:0] pv, pexp, fv, fexp, rv, rexp, nv, nexp;

    // 1. reset
    reset = 1'b1;
    x     = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
    check("rst_level", level, 4'b0000);
    check("rst_rise", rise, 4'b0000);
    check("rst_fall", fall, 4'b0000);
    check("rst_press", press, 4'b0000);
    check("rst_any", any, 1'b0);

    // 2. x[0] rises and is held; level appears 6 edges later
    x[0] = 1'b1;
    repeat (5) tick();
    check("ch0_lvl_e5", level, 4'b0000);
    tick();
    check("ch0_lvl_e6", level, 4'b0001);
    check("ch0_rise_e6", rise, 4'b0001);
    check("ch0_press_e6", press, 4'b0001);
    check("ch0_nrpress_e6", nr_press, 4'b0001);
    check("ch0_any_e6", any, 1'b1);
    tick();
    check("ch0_rise_e7", rise, 4'b0000);
    check("ch0_press0_e7", press[0], 1'b0);
    check("ch0_lvl_e7", level, 4'b0001);

    // 3. x[1] bounces: 1 x3, 0 x1, then held high
    early = 1'b0;
    x[1] = 1'b1;
    repeat (3) begin tick(); early |= rise[1] | level[1]; end
    x[1] = 1'b0;
    tick();
    early |= rise[1] | level[1];
    x[1] = 1'b1;
    repeat (5) begin tick(); early |= rise[1] | level[1]; end
    check("ch1_no_early", early, 1'b0);
    tick();
    check("ch1_lvl", level[1], 1'b1);
    check("ch1_rise", rise[1], 1'b1);

    // 4. x[2] held with repeat, released 30 cycles after rise
    x[2] = 1'b1;
    repeat (6) tick();
    check("ch2_rise_t0", rise[2], 1'b1);
    pv = '0; fv = '0; rv = '0; nv = '0;
    pv[0] = press[2];
    rv[0] = rise[2];
    nv[0] = nr_press[2];
    for (int k = 1; k < 45; k++) begin
      tick();
      pv[k] = press[2];
      fv[k] = fall[2];
      rv[k] = rise[2];
      nv[k] = nr_press[2];
      if (k == 30) x[2] = 1'b0;
    end
    pexp = '0;
    pexp[0] = 1'b1;
    pexp[10] = 1'b1;
    for (int k = 13; k < 36; k += 3) pexp[k] = 1'b1;
    fexp = '0;
    fexp[36] = 1'b1;
    rexp = 64'h1;
    nexp = 64'h1;
    check("ch2_press_seq", pv, pexp);
    check("ch2_fall_seq", fv, fexp);
    check("ch2_rise_seq", rv, rexp);
    check("ch2_nr_press_seq", nv, nexp);
    check("ch2_lvl_after", level[2], 1'b0);

    // 5. reset mid-debounce on x[3]
    x[3] = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_lvl", level, 4'b0000);
    check("rst_mid_any", any, 1'b0);
    repeat (5) tick();
    check("requal_e5", level, 4'b0000);
    tick();
    check("requal_lvl", level, 4'b1011);
    check("requal_rise", rise, 4'b1011);
    check("requal_press", press, 4'b1011);
    check("requal_nrpress", nr_press, 4'b1011);

    // 6. simultaneous fall on ch0 and rise on ch1
    x[1] = 1'b0;
    repeat (8) tick();
    check("ch1_low", level, 4'b1001);
    x[0] = 1'b0;
    x[1] = 1'b1;
    early = 1'b0;
    repeat (5) begin tick(); early |= |(rise | fall); end
    check("simul_no_early", early, 1'b0);
    tick();
    check("simul_fall", fall, 4'b0001);
    check("simul_rise", rise, 4'b0010);
    check("simul_lvl", level, 4'b1010);
    check("simul_any", any, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
